// File: rtl/dp_sched.sv
// dp_sched: sclk divider plus round-robin select-window sequencer for a bank of dp_set writers.
// Each channel gets SETUP (value snapshot), SE_CYC sclk periods of se, then GAP periods of idle select.
module dp_sched #(
  parameter int NCH    = 4,
  parameter int DIV    = 50,
  parameter int SE_CYC = 10,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [8*NCH-1:0]  vec_in,
  output logic              sclk,
  output logic [NCH-1:0]    se,
  output logic [8*NCH-1:0]  vec_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TMAX = (SE_CYC > GAP) ? SE_CYC : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);
  localparam logic [TW-1:0] SE_LAST  = TW'(SE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  logic [DW-1:0]    div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tick;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [NCH-1:0]   se_q, se_d;
  logic [8*NCH-1:0] vec_out_q, vec_out_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             latch;

  // Free-running divider; a tick is the clk cycle in which sclk rises.
  always_comb begin
    div_d  = div_q + 1'b1;
    sclk_d = sclk_q;
    tick   = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      tick   = ~sclk_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tcnt_d       = tcnt_q;
    vec_out_d    = vec_out_q;
    frame_done_d = 1'b0;
    latch        = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_SETUP;
            ch_d    = '0;
            latch   = 1'b1;
          end
        end
        ST_SETUP: begin
          state_d = ST_ACTIVE;
          tcnt_d  = '0;
        end
        ST_ACTIVE: begin
          if (tcnt_q == SE_LAST) begin
            state_d = ST_GAP;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        default: begin
          if (tcnt_q == GAP_LAST) begin
            // Dropping en skips the remaining channels; the next frame restarts at channel 0.
            frame_done_d = (ch_q == CH_LAST);
            if (en) begin
              state_d = ST_SETUP;
              ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
              latch   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              ch_d    = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      endcase
    end
    if (latch) begin
      vec_out_d[8*ch_d +: 8] = vec_in[8*ch_d +: 8];
    end
  end

  always_comb begin
    se_d = '0;
    if (state_d == ST_ACTIVE) begin
      se_d[ch_d] = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      sclk_q       <= 1'b0;
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      tcnt_q       <= '0;
      se_q         <= '0;
      vec_out_q    <= {NCH{8'h7f}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      sclk_q       <= sclk_d;
      state_q      <= state_d;
      ch_q         <= ch_d;
      tcnt_q       <= tcnt_d;
      se_q         <= se_d;
      vec_out_q    <= vec_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sclk       = sclk_q;
  assign se         = se_q;
  assign vec_out    = vec_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
